// File: rtl/clz_share_sched.sv
// clz_share_sched: one iterative count-leading-zeros engine shared by NUM_REQ
// requesters. A round-robin arbiter takes one operand at a time, a binary
// search resolves one halving level per cycle, and the result goes out on a
// single response bus tagged with the requester id.
module clz_share_sched #(
   parameter int  WIDTH   = 32,
   parameter int  NUM_REQ = 4,
   localparam int LOG2W   = $clog2(WIDTH),
   localparam int IDW     = $clog2(NUM_REQ),
   localparam int CW      = LOG2W + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [IDW-1:0]           rsp_id,
   output logic [CW-1:0]            rsp_count,
   output logic                     rsp_zero,
   input  logic                     rsp_ready,
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [LOG2W-1:0] step_q, step_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   int               arb_idx;

   logic [CW-1:0]    h;
   logic             top_zero;
   logic [WIDTH-1:0] x_step;
   logic [CW-1:0]    cnt_step;
   logic [CW-1:0]    cnt_fin;
   logic             last_step;

   // Round-robin pick: first valid requester at or after rr_q, wrapping around.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      arb_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_idx = int'(rr_q) + k;
         if (arb_idx >= NUM_REQ) begin
            arb_idx = arb_idx - NUM_REQ;
         end
         if (!gnt_found && req_valid[arb_idx[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = arb_idx[IDW-1:0];
         end
      end
   end

   // One binary-search level: test the top h bits, shift them out if all zero.
   // On the final level the leftover MSB is folded in so that an all-zero
   // operand reaches exactly WIDTH.
   always_comb begin
      h         = CW'(WIDTH >> (int'(step_q) + 1));
      top_zero  = ((x_q >> (WIDTH - int'(h))) == '0);
      x_step    = top_zero ? (x_q << h) : x_q;
      cnt_step  = top_zero ? (cnt_q + h) : cnt_q;
      last_step = (int'(step_q) == LOG2W - 1);
      cnt_fin   = cnt_step + {{(CW-1){1'b0}}, ~x_step[WIDTH-1]};
   end

   // Next-state and accept strobe for the IDLE/SEARCH/RESP sequencer.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      zero_d    = zero_q;
      x_d       = x_q;
      step_d    = step_q;
      req_ready = '0;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               req_ready[gnt_idx] = 1'b1;
               x_d     = req_data[gnt_idx*WIDTH +: WIDTH];
               id_d    = gnt_idx;
               cnt_d   = '0;
               zero_d  = 1'b0;
               step_d  = '0;
               rr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
               state_d = S_SEARCH;
            end
         end
         S_SEARCH: begin
            x_d    = x_step;
            step_d = step_q + 1'b1;
            if (last_step) begin
               cnt_d   = cnt_fin;
               zero_d  = (cnt_fin == CW'(WIDTH));
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_step;
            end
         end
         S_RESP: begin
            // Return to IDLE only; the next grant waits one cycle.
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Nothing may be accepted while reset is being applied.
      if (!reset) begin
         req_ready = '0;
      end
   end

   // Control and response registers, cleared by the synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   // Working operand and step index; always reloaded on grant, so no reset.
   always_ff @(posedge clk) begin
      x_q    <= x_d;
      step_q <= step_d;
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = id_q;
   assign rsp_count = cnt_q;
   assign rsp_zero  = zero_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_clz_share_sched.sv
// Bench for clz_share_sched: per-port operand queues feed a driver, accepted
// operands push expected responses into a scoreboard, and a monitor pops and
// compares every response the DUT hands over.
module tb_clz_share_sched;
   localparam int W     = 32;
   localparam int N     = 4;
   localparam int LOG2W = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [5:0]     rsp_count;
   logic           rsp_zero;
   logic           rsp_ready;
   logic           busy;

   typedef struct packed {
      logic [31:0] d;
      logic [5:0]  c;
   } op_t;

   typedef struct packed {
      logic [1:0]  id;
      logic [5:0]  c;
      logic        z;
      logic [31:0] acc;
   } exp_t;

   op_t  pq[N][$];
   exp_t exp_q[$];
   int   glog[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   nacc  = 0;
   int   nrsp  = 0;
   int   ndisc = 0;
   bit   rnd_mode = 1'b0;
   logic rsp_ready_man = 1'b1;
   bit   hold[N];
   bit   prev_v = 1'b0;

   clz_share_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_count (rsp_count),
      .rsp_zero  (rsp_zero),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ref_clz(logic [31:0] x);
      for (int b = 31; b >= 0; b--) begin
         if (x[b]) return 31 - b;
      end
      return 32;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic push_op(int p, logic [31:0] d, int c);
      pq[p].push_back('{d: d, c: 6'(c)});
   endtask

   function automatic bit pq_empty();
      for (int i = 0; i < N; i++) begin
         if (pq[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic wait_drain(int budget);
      int n = 0;
      while (n < budget && !(pq_empty() && exp_q.size() == 0 && !busy && !rsp_valid)) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Driver: raise and hold valid per port, record every handshake.
   initial begin
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) hold[i] = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!hold[i] && pq[i].size() > 0 && (!rnd_mode || $urandom_range(0, 2) != 0))
               hold[i] = 1'b1;
            req_valid[i] = hold[i];
            if (hold[i]) req_data[i*W +: W] = pq[i][0].d;
            else if (rnd_mode) req_data[i*W +: W] = $urandom;
            else req_data[i*W +: W] = '0;
         end
         rsp_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : rsp_ready_man;
         #1;
         if (!reset) begin
            glog.delete();
         end else begin
            chk("req_ready_onehot", 64'($countones(req_ready) > 1), 64'(0));
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  exp_q.push_back('{id: 2'(i), c: pq[i][0].c, z: (pq[i][0].c == 6'd32),
                                    acc: 32'(cyc + 1)});
                  void'(pq[i].pop_front());
                  hold[i] = 1'b0;
                  glog.push_back(i);
                  nacc++;
               end
            end
         end
      end
   end

   // Monitor: compare each presented response against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            ndisc += exp_q.size();
            exp_q.delete();
            prev_v = 1'b0;
         end else if (rsp_valid) begin
            chk("req_ready_in_resp", 64'(req_ready), 64'(0));
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp: got id %0d count %0d want none", rsp_id, rsp_count);
            end else begin
               if (!prev_v) chk("latency", 64'(cyc) - 64'(exp_q[0].acc), 64'(LOG2W));
               chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
               chk("rsp_count", 64'(rsp_count), 64'(exp_q[0].c));
               chk("rsp_zero", 64'(rsp_zero), 64'(exp_q[0].z));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  nrsp++;
               end
            end
            prev_v = !rsp_ready;
         end else begin
            prev_v = 1'b0;
         end
      end
   end

   // Main sequence of directed and random scenarios.
   initial begin
      int rr_exp[5] = '{0, 1, 2, 3, 0};
      int t5_exp[4] = '{0, 1, 2, 3};
      int n;
      reset = 1'b0;
      rsp_ready_man = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_rsp_count", 64'(rsp_count), 64'(0));
      chk("rst_rsp_zero", 64'(rsp_zero), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      reset = 1'b1;

      // single requester
      push_op(0, 32'h00000ABC, 20);
      wait_drain(100);

      // boundary operands on requester 1
      push_op(1, 32'h00000000, 32);
      push_op(1, 32'h80000000, 0);
      push_op(1, 32'h00000001, 31);
      push_op(1, 32'hFFFFFFFF, 0);
      push_op(1, 32'h00010000, 15);
      wait_drain(200);

      // round-robin with all requesters valid
      do_reset();
      push_op(0, 32'h00F00000, 8);
      push_op(1, 32'h00000001, 31);
      push_op(2, 32'h40000000, 1);
      push_op(3, 32'h0000FFFF, 16);
      push_op(0, 32'h00000000, 32);
      wait_drain(200);
      chk("rr_count", 64'(glog.size()), 64'(5));
      for (int k = 0; k < 5; k++)
         chk($sformatf("rr_order%0d", k), 64'((k < glog.size()) ? glog[k] : -1), 64'(rr_exp[k]));

      // response backpressure
      rsp_ready_man = 1'b0;
      push_op(1, 32'h00000300, 22);
      push_op(2, 32'h08000000, 4);
      n = 0;
      while (n < 30 && !rsp_valid) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk("bp_rsp_seen", 64'(rsp_valid), 64'(1));
      repeat (10) begin
         @(negedge clk);
         #3;
         chk("bp_valid_held", 64'(rsp_valid), 64'(1));
         chk("bp_req_ready", 64'(req_ready), 64'(0));
         chk("bp_busy", 64'(busy), 64'(1));
      end
      chk("bp_no_grant", 64'(glog.size()), 64'(6));
      @(negedge clk);
      rsp_ready_man = 1'b1;
      wait_drain(200);
      chk("bp_grants", 64'(glog.size()), 64'(7));
      chk("bp_grant5", 64'((glog.size() > 5) ? glog[5] : -1), 64'(1));
      chk("bp_grant6", 64'((glog.size() > 6) ? glog[6] : -1), 64'(2));

      // reset in the middle of a search
      do_reset();
      push_op(0, 32'h12345678, 3);
      push_op(0, 32'h00400000, 9);
      push_op(1, 32'h00000002, 30);
      push_op(2, 32'h00008000, 16);
      push_op(3, 32'h01000000, 7);
      n = 0;
      while (n < 20 && !busy) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk("mid_busy_seen", 64'(busy), 64'(1));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #3;
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("mid_rst_rsp_count", 64'(rsp_count), 64'(0));
      chk("mid_rst_rsp_zero", 64'(rsp_zero), 64'(0));
      chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      wait_drain(200);
      chk("mid_grants", 64'(glog.size()), 64'(4));
      for (int k = 0; k < 4; k++)
         chk($sformatf("mid_order%0d", k), 64'((k < glog.size()) ? glog[k] : -1), 64'(t5_exp[k]));

      // random operands, valids and rsp_ready
      rnd_mode = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         logic [31:0] r;
         logic [31:0] d;
         int sh;
         r  = $urandom;
         sh = $urandom_range(0, 32);
         d  = (sh == 32) ? 32'h0 : (r >> sh);
         push_op($urandom_range(0, 3), d, ref_clz(d));
      end
      wait_drain(60000);
      rnd_mode = 1'b0;
      repeat (2) @(negedge clk);

      chk("accept_vs_rsp", 64'(nrsp + ndisc), 64'(nacc));
      chk("discarded", 64'(ndisc), 64'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
